kan_input_dispatcher: RTL
=========================

Name: kan_input_dispatcher

Overview:
Upstream feeder for the KAN multi-core array. Accepts a serial valid/ready sample stream and packs it into 16-lane input vectors. Picks an idle, enabled core by round-robin, writes the vector into that core's input slice and pulses the matching core-select bit. Drives the multi-core block's per-core input data and core_select ports directly.

Parameters:
NUM_CORES, 8, number of processing cores fed (1..8)
DATA_WIDTH, 16, sample width in bits
LANES, 16, words per core input vector
TIMEOUT_CYCLES, 1024, stall limit for the optional timeout feature

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input sample valid
s_ready  output  1  dispatcher can accept a sample
s_data  input  DATA_WIDTH  input sample
s_last  input  1  last sample of the current vector (early terminate)
core_enable_mask  input  NUM_CORES  cores allowed to receive work
core_ready_in  input  NUM_CORES  per-core idle/ready status from the core array
core_data_out  output  NUM_CORES*LANES*DATA_WIDTH  flattened core inputs; core c lane l at bit offset (c*LANES+l)*DATA_WIDTH
core_select_out  output  8  one-hot dispatch pulse; bits >= NUM_CORES are always 0
dispatch_count  output  16  vectors dispatched, wraps modulo 2^16
stall_cycles  output  16  cycles spent in ARB without a grant, saturates at 0xFFFF
timeout_err  output  1  sticky timeout flag (optional feature)

Behaviour:
- Reset: clk and rst_n as already decided; reset is asynchronous, active-low. On reset, state=FILL, lane_idx=0, staging buffer=0, rr_ptr=0, core_data_out=0, core_select_out=0, dispatch_count=0, stall_cycles=0, timeout_err=0.
- Reset mid-operation discards any partial vector and any pending dispatch. s_ready is 0 while rst_n is low.
- s_ready=1 only in FILL. A sample transfers when s_valid && s_ready.
- FILL:
  - Each transfer writes stage[lane_idx] and increments lane_idx.
  - If lane_idx==LANES-1 or s_last=1, go to ARB next cycle.
  - Lanes not written keep 0 (the stage is cleared when FILL is re-entered), so a vector ended by s_last is zero-padded.
  - s_last together with lane LANES-1 behaves as a normal full vector.
- ARB (s_ready=0):
  - Combinational search over candidates rr_ptr, rr_ptr+1, … mod NUM_CORES. The first c with core_ready_in[c] && core_enable_mask[c] wins.
  - On a grant: latch target=c and go to ISSUE. At the same edge, write core_data_out slice[c] with the stage.
  - With no grant: stay in ARB and increment stall_cycles (saturating).
- ISSUE (one cycle, s_ready=0):
  - core_select_out = one-hot(target) for exactly this cycle; 0 in every other state.
  - At the end of the cycle: rr_ptr = (target+1) mod NUM_CORES, dispatch_count++, stage cleared, lane_idx=0, go to FILL.
- Latency: last sample accepted at edge N. ARB during cycle N+1. With a core available, core_data_out is updated and core_select_out is high during cycle N+2, and s_ready returns to 1 in cycle N+3.
- Data stability: a core's slice changes only when that core is dispatched, and holds otherwise.
- Inputs that change after the grant: core_ready_in deasserting after the grant does not cancel the dispatch. core_enable_mask changes take effect at the next ARB evaluation.
- All-zero mask, or no ready core: remain in ARB indefinitely (unless the optional timeout feature is compiled in).

Optional Feature:
KAN_DISPATCH_TIMEOUT_EN
- Defined: a per-vector wait counter runs in ARB. When it reaches TIMEOUT_CYCLES without a grant, the vector is dropped. timeout_err is set sticky until reset, the state returns to FILL with the stage cleared, and dispatch_count is unchanged.
- Undefined: no counter exists, timeout_err is tied to 0, and ARB waits forever.

Test Plan:
- Reset, then 16 samples 0x0001..0x0010 with all cores ready and mask=0xFF -> core 0 slice lanes = 1..16, core_select_out=0x01 for one cycle at N+2, dispatch_count=1.
- Two more full vectors -> dispatched to core 1 then core 2 (select 0x02, 0x04); rr_ptr wraps from core 7 to core 0 after 8 dispatches; core 0 slice is untouched until its next turn.
- 3 samples with s_last on the third -> lanes 0..2 hold the data, lanes 3..15 = 0.
- core_ready_in=0x00 for 20 cycles, then 0x10 -> stall_cycles=20, dispatch goes to core 4, s_ready=0 throughout the wait.
- Assert rst_n low while lane_idx=7 -> all outputs return to 0; a following full vector goes to core 0.
- With KAN_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8 and mask=0 -> timeout_err=1 after 8 ARB cycles, s_ready=1 again, dispatch_count unchanged.

Source files
------------

// File: rtl/kan_input_dispatcher.sv
// kan_input_dispatcher: packs a serial sample stream into LANES-wide vectors and dispatches each
// to an idle, enabled core by round-robin. Optional stall timeout: KAN_DISPATCH_TIMEOUT_EN.
module kan_input_dispatcher #(
    parameter int unsigned NUM_CORES      = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned LANES          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    input  logic                                  s_last,
    input  logic [NUM_CORES-1:0]                  core_enable_mask,
    input  logic [NUM_CORES-1:0]                  core_ready_in,
    output logic [NUM_CORES*LANES*DATA_WIDTH-1:0] core_data_out,
    output logic [7:0]                            core_select_out,
    output logic [15:0]                           dispatch_count,
    output logic [15:0]                           stall_cycles,
    output logic                                  timeout_err
);
    localparam int unsigned PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    if (NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("kan_input_dispatcher: invalid parameters");
    end

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   stage_q [LANES];
    logic [DATA_WIDTH-1:0]   core_q  [NUM_CORES][LANES];
    logic [LANE_W-1:0]       lane_idx_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        target_q;
    logic [PTR_W-1:0]        grant_idx_c;
    logic                    grant_c;
    logic                    xfer_c;
    logic                    drop_c;
    logic [2*NUM_CORES-1:0]  elig2_c;
    logic [NUM_CORES-1:0]    rot_c;
    int unsigned             sum_c;
    logic                    s_ready_q;
    logic [7:0]              sel_q;
    logic [15:0]             count_q;
    logic [15:0]             stall_q;

`ifdef KAN_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_q;
    logic            err_q;
`endif

    // Next-state, rotating-priority arbiter and timeout decision
    always_comb begin
        state_d     = state_q;
        grant_c     = 1'b0;
        grant_idx_c = '0;
        drop_c      = 1'b0;
        sum_c       = 0;
        xfer_c      = s_valid && s_ready_q;
        elig2_c     = {core_ready_in & core_enable_mask, core_ready_in & core_enable_mask} >> rr_ptr_q;
        rot_c       = elig2_c[NUM_CORES-1:0];

        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                grant_c = 1'b1;
                sum_c   = 32'(rr_ptr_q) + 32'(i);
            end
        end
        if (sum_c >= NUM_CORES) sum_c = sum_c - NUM_CORES;
        grant_idx_c = PTR_W'(sum_c);

`ifdef KAN_DISPATCH_TIMEOUT_EN
        drop_c = (state_q == ARB) && !grant_c && (32'(wait_q) == TIMEOUT_CYCLES - 1);
`endif

        case (state_q)
            FILL:    if (xfer_c && ((lane_idx_q == LANE_W'(LANES - 1)) || s_last)) state_d = ARB;
            ARB: begin
                if (grant_c)     state_d = ISSUE;
                else if (drop_c) state_d = FILL;
            end
            ISSUE:   state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Datapath: staging buffer, core slices, pointers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) stage_q[l] <= '0;
            for (int c = 0; c < NUM_CORES; c++)
                for (int l = 0; l < LANES; l++) core_q[c][l] <= '0;
            lane_idx_q <= '0;
            rr_ptr_q   <= '0;
            target_q   <= '0;
            s_ready_q  <= 1'b0;
            sel_q      <= '0;
            count_q    <= '0;
            stall_q    <= '0;
        end else begin
            sel_q     <= '0;
            s_ready_q <= (state_d == FILL);
            case (state_q)
                FILL: begin
                    if (xfer_c) begin
                        stage_q[lane_idx_q] <= s_data;
                        lane_idx_q          <= lane_idx_q + LANE_W'(1);
                    end
                end
                ARB: begin
                    if (grant_c) begin
                        target_q            <= grant_idx_c;
                        core_q[grant_idx_c] <= stage_q;
                        sel_q               <= 8'(1) << grant_idx_c;
                    end else begin
                        if (stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
                        if (drop_c) begin
                            for (int l = 0; l < LANES; l++) stage_q[l] <= '0;
                            lane_idx_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    rr_ptr_q <= (32'(target_q) == NUM_CORES - 1) ? '0 : target_q + PTR_W'(1);
                    count_q  <= count_q + 16'd1;
                    for (int l = 0; l < LANES; l++) stage_q[l] <= '0;
                    lane_idx_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef KAN_DISPATCH_TIMEOUT_EN
    // Per-vector wait counter; the error flag stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ARB && !grant_c && !drop_c) wait_q <= wait_q + TO_W'(1);
            else                                       wait_q <= '0;
            if (drop_c) err_q <= 1'b1;
        end
    end
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign core_data_out[(c*LANES+l)*DATA_WIDTH +: DATA_WIDTH] = core_q[c][l];
        end
    end

    assign s_ready         = s_ready_q;
    assign core_select_out = sel_q;
    assign dispatch_count  = count_q;
    assign stall_cycles    = stall_q;
endmodule
